scale_down_nch: RTL
===================

// Module: scale_down_nch
// PURPOSE
//  Parametrised N-channel fixed-point downscaler (nearest-neighbour or 2-tap horizontal average), single clock domain.
//  Takes a packed pixel stream with vs/de framing and keeps source pixels/lines chosen by Q8.8 phase accumulators.
//  Kept pixels go to an internal output FIFO with a valid/ready interface toward the frame-buffer writer.
//  Replaces the per-colour scaler triplet: one instance handles all channels in lockstep.
// PARAMETERS
//  NCH    3   number of colour channels
//  CW     8   bits per channel; pixel_data is NCH*CW wide, channel 0 in LSBs
//  DW     12  width of dimension inputs and internal x/y counters
//  DEPTH  16  output FIFO depth, power of two, >= 4
// PORTS
//  pixel_clk  in   1        pixel clock; all logic on rising edge
//  sys_rst_n  in   1        synchronous active-low reset
//  vs         in   1        frame sync, active high; rising edge starts a frame
//  de         in   1        data enable; falling edge ends a source line
//  pixel_data in   NCH*CW   source pixel, valid when de=1
//  s_width    in   DW       source width in pixels; sampled on vs rising edge
//  s_height   in   DW       source height in lines; sampled on vs rising edge
//  h_scale_k  in   16       Q8.8 horizontal step (source px per output px); sampled on vs rise
//  v_scale_k  in   16       Q8.8 vertical step; sampled on vs rise
//  avg_mode   in   1        0 = nearest, 1 = 2-tap horizontal average; sampled on vs rise
//  out_data   out  NCH*CW   FIFO head pixel
//  out_valid  out  1        FIFO non-empty
//  out_ready  in   1        consumer pop; pop occurs when out_valid & out_ready
//  overflow   out  1        sticky: a kept pixel was dropped because the FIFO was full
//  out_count  out  2*DW     kept pixels written this frame
// BEHAVIOUR
//  Reset (sys_rst_n=0 at an edge):
//   - FIFO emptied; all counters and accumulators cleared.
//   - out_valid=0, out_data=0, overflow=0, out_count=0.
//   - Applies mid-frame as well; no output until the next vs rising edge.
//  Frame start (vs 0->1):
//   - Latch s_width, s_height, h_scale_k, v_scale_k and avg_mode.
//   - Clamp any step below 16'h0100 to 16'h0100; no upscaling.
//   - Clear y, v_acc, overflow and out_count. The FIFO is not flushed.
//  Line handling:
//   - x counts de=1 cycles from 0; de falling edge: y++, x=0, h_acc=0.
//   - Line kept iff y == v_acc[DW+7:8]; on leaving a kept line, v_acc += v_scale_k.
//   - Lines with y >= s_height and pixels with x >= s_width are ignored.
//  Pixel selection:
//   - Pixel kept iff de & kept line & x == h_acc[DW+7:8]; on a keep, h_acc += h_scale_k.
//   - h_acc and v_acc are DW+8 bits wide.
//  Average mode:
//   - Per channel out = (cur + prev + 1) >> 1, computed at CW+1 bits.
//   - prev is the previous source pixel of the same line; at x=0, prev = cur.
//  Latency: a kept pixel at cycle N is written to the FIFO at N+1 (one register stage).
//   out_valid is asserted at N+2 if the FIFO was empty (registered show-ahead head).
//  FIFO:
//   - Simultaneous write and pop when full is allowed; the write succeeds.
//   - A write when full with no pop drops the pixel and sets overflow.
//   - out_count counts only successful writes.
//   - Ordering is strict FIFO; out_data holds while out_valid & !out_ready.
//  vs rising edge while de=1: treated as a new frame; the current partial line is abandoned.
// TESTING
//  1. 8x4 frame, k_h=k_v=0x0200, ready=1 -> 4x2=8 outputs: x{0,2,4,6} of rows {0,2}; out_count=8.
//  2. 8x1 frame, k_h=0x0180 -> keeps x{0,1,3,4,6,7}; k=0x0080 -> clamped, all 8 kept.
//  3. avg_mode=1, k_h=0x0200, row pixels 10,20,30,40 (all channels) -> outputs 10 (x0: prev=cur), 25.
//  4. out_ready=0, 20 kept pixels, DEPTH=16 -> 16 stored, overflow=1, out_count=16; then drain 16 in order.
//  5. Reset asserted mid-line with FIFO holding 5 -> next edge: out_valid=0, overflow=0; no output until vs rise.
//  6. Full FIFO with write and pop in the same cycle -> no drop, overflow stays 0, order preserved.

Source files
------------

// File: rtl/scale_down_nch.sv
// N-channel nearest/2-tap-average downscaler driven by Q8.8 phase accumulators,
// with a registered show-ahead output FIFO toward the frame-buffer writer.
module scale_down_nch #(
  parameter int NCH   = 3,
  parameter int CW    = 8,
  parameter int DW    = 12,
  parameter int DEPTH = 16
) (
  input  logic                pixel_clk,
  input  logic                sys_rst_n,
  input  logic                vs,
  input  logic                de,
  input  logic [NCH*CW-1:0]   pixel_data,
  input  logic [DW-1:0]       s_width,
  input  logic [DW-1:0]       s_height,
  input  logic [15:0]         h_scale_k,
  input  logic [15:0]         v_scale_k,
  input  logic                avg_mode,
  output logic [NCH*CW-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic [2*DW-1:0]     out_count
);

  localparam int PW     = NCH * CW;
  localparam int AW     = $clog2(DEPTH);
  localparam int ACC_W  = DW + 8;
  localparam logic [15:0] K_MIN    = 16'h0100;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  function automatic logic [15:0] clamp_step(input logic [15:0] k);
    return (k < K_MIN) ? K_MIN : k;
  endfunction

  logic              vs_d_r, de_d_r, active_r, avg_r;
  logic [DW-1:0]     x_r, y_r, width_r, height_r;
  logic [ACC_W-1:0]  h_acc_r, v_acc_r;
  logic [15:0]       hk_r, vk_r;
  logic [PW-1:0]     prev_r, wr_data_r;
  logic              wr_en_r;

  logic [PW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [AW:0]       cnt_r;
  logic [PW-1:0]     out_data_r;
  logic              out_valid_r, overflow_r;
  logic [2*DW-1:0]   out_count_r;

  logic              vs_rise_s, de_fall_s, line_kept_s, keep_s;
  logic [PW-1:0]     prev_sel_s, avg_pix_s;
  logic [ACC_W-1:0]  hk_ext_s, vk_ext_s;
  logic              pop_s, wr_ok_s;
  logic [AW:0]       cnt_next_s;
  logic [AW-1:0]     rd_next_s;

  assign vs_rise_s   = vs & ~vs_d_r;
  assign de_fall_s   = de_d_r & ~de;
  assign line_kept_s = active_r && (y_r < height_r) && (y_r == v_acc_r[ACC_W-1:8]);
  assign keep_s      = active_r && !vs_rise_s && de && line_kept_s &&
                       (x_r < width_r) && (x_r == h_acc_r[ACC_W-1:8]);
  assign prev_sel_s  = (x_r == {DW{1'b0}}) ? pixel_data : prev_r;
  assign hk_ext_s    = {{(ACC_W-16){1'b0}}, hk_r};
  assign vk_ext_s    = {{(ACC_W-16){1'b0}}, vk_r};

  // Per-channel rounded mean of the current and previous source pixel
  always_comb begin
    logic [CW:0] sum_v;
    avg_pix_s = {PW{1'b0}};
    sum_v     = {(CW+1){1'b0}};
    for (int c = 0; c < NCH; c++) begin
      sum_v = {1'b0, pixel_data[c*CW +: CW]} + {1'b0, prev_sel_s[c*CW +: CW]} +
              {{CW{1'b0}}, 1'b1};
      avg_pix_s[c*CW +: CW] = CW'(sum_v >> 1);
    end
  end

  // Frame/line tracking, phase accumulators and the one-cycle write stage
  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      vs_d_r    <= 1'b1;  // a vs held high through reset is not a new frame
      de_d_r    <= 1'b0;
      active_r  <= 1'b0;
      avg_r     <= 1'b0;
      x_r       <= {DW{1'b0}};
      y_r       <= {DW{1'b0}};
      width_r   <= {DW{1'b0}};
      height_r  <= {DW{1'b0}};
      h_acc_r   <= {ACC_W{1'b0}};
      v_acc_r   <= {ACC_W{1'b0}};
      hk_r      <= K_MIN;
      vk_r      <= K_MIN;
      prev_r    <= {PW{1'b0}};
      wr_en_r   <= 1'b0;
      wr_data_r <= {PW{1'b0}};
    end else begin
      vs_d_r <= vs;
      de_d_r <= de;
      if (vs_rise_s) begin
        active_r <= 1'b1;
        width_r  <= s_width;
        height_r <= s_height;
        hk_r     <= clamp_step(h_scale_k);
        vk_r     <= clamp_step(v_scale_k);
        avg_r    <= avg_mode;
        x_r      <= {DW{1'b0}};
        y_r      <= {DW{1'b0}};
        h_acc_r  <= {ACC_W{1'b0}};
        v_acc_r  <= {ACC_W{1'b0}};
      end else if (de_fall_s) begin
        x_r     <= {DW{1'b0}};
        y_r     <= y_r + {{(DW-1){1'b0}}, 1'b1};
        h_acc_r <= {ACC_W{1'b0}};
        if (y_r == v_acc_r[ACC_W-1:8]) begin
          v_acc_r <= v_acc_r + vk_ext_s;
        end
      end else if (de) begin
        x_r <= x_r + {{(DW-1){1'b0}}, 1'b1};
        if (keep_s) begin
          h_acc_r <= h_acc_r + hk_ext_s;
        end
      end
      if (de) begin
        prev_r <= pixel_data;
      end
      wr_en_r   <= keep_s;
      wr_data_r <= avg_r ? avg_pix_s : pixel_data;
    end
  end

  assign pop_s      = out_valid_r & out_ready;
  assign wr_ok_s    = wr_en_r & ((cnt_r != CNT_FULL) | pop_s);
  assign cnt_next_s = cnt_r + {{AW{1'b0}}, wr_ok_s} - {{AW{1'b0}}, pop_s};
  assign rd_next_s  = rd_ptr_r + {{(AW-1){1'b0}}, pop_s};

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge pixel_clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data_r;
    end
  end

  // FIFO pointers, registered show-ahead head and per-frame status
  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      cnt_r       <= {(AW+1){1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {PW{1'b0}};
      overflow_r  <= 1'b0;
      out_count_r <= {(2*DW){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      rd_ptr_r    <= rd_next_s;
      cnt_r       <= cnt_next_s;
      out_valid_r <= (cnt_next_s != {(AW+1){1'b0}});
      // When the FIFO drains to empty this cycle, the incoming write becomes the head
      if (cnt_next_s != {(AW+1){1'b0}}) begin
        out_data_r <= (cnt_r == {{AW{1'b0}}, pop_s}) ? wr_data_r : mem_r[rd_next_s];
      end
      if (vs_rise_s) begin
        overflow_r  <= 1'b0;
        out_count_r <= {(2*DW){1'b0}};
      end else begin
        if (wr_en_r && !wr_ok_s) begin
          overflow_r <= 1'b1;
        end
        if (wr_ok_s) begin
          out_count_r <= out_count_r + {{(2*DW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign overflow  = overflow_r;
  assign out_count = out_count_r;

endmodule
